// File: rtl/rotr8_seq_if.sv
// rtl/rotr8_seq_if.sv - request/result handshake bundle for the iterative right rotator
interface rotr8_seq_if #(
    parameter int W  = 8,
    parameter int SW = 3
);
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in;
    logic [SW-1:0] s;
    logic          op_valid;
    logic          op_ready;
    logic [W-1:0]  op;

    // Producer of requests and consumer of results
    modport master (
        output in_valid, in, s, op_ready,
        input  in_ready, op_valid, op
    );

    // The rotator itself
    modport slave (
        input  in_valid, in, s, op_ready,
        output in_ready, op_valid, op
    );
endinterface

// File: rtl/rotr8_seq.sv
// rtl/rotr8_seq.sv - iterative rotate-right, one bit position per clock
module rotr8_seq #(
    parameter int W  = 8,
    parameter int SW = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    rotr8_seq_if.slave  bus,
    output logic        busy
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  data_q, data_d;
    logic [SW-1:0] cnt_q, cnt_d;

    // State, data and remaining-step count; reset discards any in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: load on accept, rotate one place per SHIFT cycle, hold in DONE until taken
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    data_d  = bus.in;
                    cnt_d   = bus.s;
                    state_d = (bus.s == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                data_d = {data_q[0], data_q[W-1:1]};
                // The count is at least 1 here; the guard keeps it from ever wrapping
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - SW'(1);
                end
                if (cnt_q <= SW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.op_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake flags are pure state decodes; the result is the data register itself
    assign bus.in_ready = (state_q == IDLE);
    assign bus.op_valid = (state_q == DONE);
    assign bus.op       = data_q;
    assign busy         = (state_q != IDLE);
endmodule

// File: doc/rotr8_seq.md
ROTR8_SEQ -- requirements
Module: rotr8_seq

Interface
REQ-001 The block SHALL have parameter W, default 8, data width in bits; only 8 is supported.
REQ-002 The block SHALL have parameter SW, default 3, shift-amount width in bits; only 3 is supported.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port in_valid  input  1  request carries a valid word and shift amount.
REQ-006 Port in_ready  output  1  block can accept a request.
REQ-007 Port in  input  8  word to be rotated right.
REQ-008 Port s  input  3  rotate-right amount, 0..7.
REQ-009 Port op_valid  output  1  result on op is valid.
REQ-010 Port op_ready  input  1  consumer accepts the result.
REQ-011 Port op  output  8  rotated result.
REQ-012 Port busy  output  1  block is not in IDLE.

Function
REQ-013 The block SHALL implement the inverse of the team's left-rotating barrel shifter: op = in rotated right by s, so that feeding it the output of a left rotation by s restores the original word.
REQ-014 The block SHALL perform the rotation iteratively, one bit position per clock, using a three-state FSM: IDLE, SHIFT, DONE.
REQ-015 in_ready SHALL be 1 exactly when state is IDLE, decoded from state with no input dependence.
REQ-016 Accept SHALL occur on an edge where in_valid and in_ready are both 1, with the following effects:
- data register loads in
- counter loads s
- next state is DONE if s = 0, otherwise SHIFT
REQ-017 In SHIFT, each edge SHALL rotate data right by one and decrement the counter; when the counter is 1 before the edge, next state is DONE.
REQ-018 Latency SHALL be as follows:
- accept in cycle k gives op_valid = 1 in cycle k+1+s
- s = 0 gives 1 cycle; s = 7 gives 8 cycles
REQ-019 In DONE, op_valid SHALL be 1 and op SHALL equal the data register.
REQ-020 op SHALL be registered and held stable while op_valid = 1 and op_ready = 0, for any number of cycles.
REQ-021 An edge in DONE with op_ready = 1 SHALL return the FSM to IDLE, so in_ready = 1 in the next cycle.
REQ-022 Requests SHALL NOT be accepted outside IDLE; in_valid in SHIFT or DONE SHALL be ignored and cause no state change.
REQ-023 Rotate arithmetic SHALL be performed as follows:
- bit 0 moves to bit 7 on each step
- no bits are lost
- the counter never underflows and never wraps
REQ-024 op_ready in IDLE or SHIFT SHALL have no effect.
REQ-025 busy SHALL be 1 in SHIFT and DONE, and 0 in IDLE.
REQ-026 Maximum throughput SHALL be one result per s+2 cycles (accept, s shifts, handoff), with IDLE occupying at least one cycle between results.

Reset
REQ-027 While rst_n = 0, the block SHALL immediately, without waiting for clk, force:
- state to IDLE
- data to 8'h00, counter to 3'b000
- op to 8'h00, op_valid to 0, busy to 0
- in_ready to 1
REQ-028 Reset asserted mid-SHIFT or in DONE SHALL discard the in-flight operation with no result emitted; after release the first edge with in_valid = 1 SHALL accept a new request.
REQ-029 The block SHALL hold rst_n release timing to the requirement that no accept occurs on an edge coincident with rst_n rising.

Verification
REQ-030 Bench: in=8'h0F, s=1, accept, op_ready=1 -> op_valid in cycle k+2 with op=8'h87, then in_ready=1 next cycle.
REQ-031 Bench: in=8'hA5, s=0 -> op_valid in cycle k+1, op=8'hA5.
REQ-032 Bench: round trip of in=8'h87 (8'hF0 rotated left by 3), s=3 -> op=8'hF0 in cycle k+4; in=8'h01, s=7 -> op=8'h02 in cycle k+8.
REQ-033 Bench: in=8'h0F, s=4, op_ready=0 for 5 cycles after op_valid -> op=8'hF0 stable throughout, in_ready=0; op_ready=1 -> IDLE.
REQ-034 Bench: in_valid pulsed with in=8'hFF while in SHIFT -> ignored, original result unaffected.
REQ-035 Bench: rst_n=0 two cycles after accepting s=6 -> op=8'h00, op_valid=0, busy=0 immediately; no result emitted after release.
